// File: rtl/sdi_bridge_pkg.sv
// Shared state, register map, mode codes and resolution constants for the SDI-to-CSI-2 bridge control path.
// Pure definitions: no latency and no flow control of its own.
package sdi_bridge_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE  = 2'd0,
    ST_CONFIG   = 2'd1,
    ST_RUN      = 2'd2,
    ST_TEARDOWN = 2'd3
  } state_e;

  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_H_ACTIVE = 4'd1;
  localparam logic [3:0] ADDR_V_ACTIVE = 4'd2;
  localparam logic [3:0] ADDR_WC       = 4'd3;

  localparam logic [15:0] CTRL_DISABLE = 16'd0;
  localparam logic [15:0] CTRL_ENABLE  = 16'd1;

  localparam logic [1:0] MODE_NONE  = 2'd0;
  localparam logic [1:0] MODE_720P  = 2'd1;
  localparam logic [1:0] MODE_1080P = 2'd2;
  localparam logic [1:0] MODE_UNSUP = 2'd3;

  localparam logic [11:0] H_720P  = 12'd1280;
  localparam logic [10:0] V_720P  = 11'd720;
  localparam logic [11:0] H_1080P = 12'd1920;
  localparam logic [10:0] V_1080P = 11'd1080;

  localparam logic [2:0] CFG_STEP_LAST = 3'd4;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } cfg_wr_t;

  function automatic logic [1:0] mode_of(input logic [11:0] h, input logic [10:0] v);
    logic [1:0] m;
    m = MODE_UNSUP;
    if (h == H_720P && v == V_720P) begin
      m = MODE_720P;
    end else if (h == H_1080P && v == V_1080P) begin
      m = MODE_1080P;
    end
    return m;
  endfunction

  // Transmitter programming sequence; step 0 doubles as the teardown write.
  function automatic cfg_wr_t cfg_step(input logic [2:0] step, input logic [11:0] h,
                                       input logic [10:0] v);
    cfg_wr_t w;
    w.addr = ADDR_CTRL;
    w.data = CTRL_DISABLE;
    case (step)
      3'd1: begin
        w.addr = ADDR_H_ACTIVE;
        w.data = {4'd0, h};
      end
      3'd2: begin
        w.addr = ADDR_V_ACTIVE;
        w.data = {5'd0, v};
      end
      3'd3: begin
        w.addr = ADDR_WC;
        w.data = {3'd0, h, 1'b0};
      end
      3'd4: begin
        w.addr = ADDR_CTRL;
        w.data = CTRL_ENABLE;
      end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cfg_writer.sv
// Single register-write engine: wr/addr/data rise the cycle after start and hold until ack or ACK_TIMEOUT cycles.
// Start is honoured only while idle; done/timeout are combinational strobes in the closing cycle.
module cfg_writer
  import sdi_bridge_pkg::*;
#(
  parameter int ACK_TIMEOUT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [3:0]  i_addr,
  input  logic [15:0] i_data,
  input  logic        i_ack,
  output logic        o_wr,
  output logic [3:0]  o_addr,
  output logic [15:0] o_data,
  output logic        o_done,
  output logic        o_timeout
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(ACK_TIMEOUT - 1);

  logic          r_wr;
  cfg_wr_t       r_req;
  logic [TW-1:0] r_wait;

  assign o_done    = r_wr & i_ack;
  assign o_timeout = r_wr & ~i_ack & (r_wait == WAIT_LAST);
  assign o_wr      = r_wr;
  assign o_addr    = r_req.addr;
  assign o_data    = r_req.data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr   <= 1'b0;
      r_req  <= '0;
      r_wait <= '0;
    end else if (r_wr) begin
      if (o_done || o_timeout) begin
        r_wr <= 1'b0;
      end else begin
        r_wait <= r_wait + TW'(1);
      end
    end else if (i_start) begin
      r_wr       <= 1'b1;
      r_req.addr <= i_addr;
      r_req.data <= i_data;
      r_wait     <= '0;
    end
  end

endmodule

// File: rtl/format_ctrl.sv
// Qualifies detector measurements, programs the CSI-2 transmitter and enables the bridge; tears down on loss.
// Writes start the cycle after the qualifying pulse; each write waits for ack (bounded by ACK_TIMEOUT).
module format_ctrl
  import sdi_bridge_pkg::*;
#(
  parameter int STABLE_FRAMES = 3,
  parameter int LOSS_TIMEOUT  = 2_000_000,
  parameter int ACK_TIMEOUT   = 256
) (
  input  logic        sys_clk,
  input  logic        n_rst,
  input  logic        det_valid_i,
  input  logic [11:0] det_h_active_i,
  input  logic [10:0] det_v_active_i,
  output logic        cfg_wr_o,
  output logic [3:0]  cfg_addr_o,
  output logic [15:0] cfg_data_o,
  input  logic        cfg_ack_i,
  output logic        bridge_en_o,
  output logic        locked_o,
  output logic [1:0]  mode_o,
  output logic        err_o
);

  localparam int CW = $clog2(STABLE_FRAMES + 1);
  localparam int WW = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_STABLE = CW'(STABLE_FRAMES);
  localparam logic [WW-1:0] WDOG_MAX   = WW'(LOSS_TIMEOUT);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(LOSS_TIMEOUT - 1);

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [11:0]   r_ref_h, w_ref_h_nxt;
  logic [10:0]   r_ref_v, w_ref_v_nxt;
  logic [2:0]    r_step, w_step_nxt;
  logic [1:0]    r_mode, w_mode_nxt;
  logic          r_err, w_err_nxt;
  logic          r_bridge_en, r_locked;
  logic [WW-1:0] r_wdog;

  logic          w_match, w_expire, w_start, w_done, w_tmo, w_run_nxt;
  logic [1:0]    w_det_mode;
  cfg_wr_t       w_req;

  assign w_match    = (det_h_active_i == r_ref_h) && (det_v_active_i == r_ref_v);
  assign w_cnt_inc  = (r_cnt == CNT_STABLE) ? r_cnt : r_cnt + CW'(1);
  assign w_det_mode = mode_of(det_h_active_i, det_v_active_i);
  // A pulse in the expiry cycle wins over the timeout.
  assign w_expire   = !det_valid_i && (r_wdog >= WDOG_LAST);
  assign w_run_nxt  = (w_state_nxt == ST_RUN);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ref_h_nxt = r_ref_h;
    w_ref_v_nxt = r_ref_v;
    w_step_nxt  = r_step;
    w_mode_nxt  = r_mode;
    w_err_nxt   = r_err;
    w_start     = 1'b0;
    w_req       = cfg_step(r_step, r_ref_h, r_ref_v);
    case (r_state)
      ST_ACQUIRE: begin
        if (det_valid_i) begin
          if (w_match) begin
            w_cnt_nxt = w_cnt_inc;
          end else begin
            w_cnt_nxt   = CW'(1);
            w_ref_h_nxt = det_h_active_i;
            w_ref_v_nxt = det_v_active_i;
          end
          if (w_cnt_nxt == CNT_STABLE) begin
            if (w_det_mode != MODE_UNSUP) begin
              w_mode_nxt  = w_det_mode;
              w_state_nxt = ST_CONFIG;
              w_step_nxt  = 3'd0;
              w_start     = 1'b1;
              w_req       = cfg_step(3'd0, det_h_active_i, det_v_active_i);
            end else begin
              w_mode_nxt = MODE_UNSUP;
            end
          end
        end else if (w_expire) begin
          w_cnt_nxt  = '0;
          w_mode_nxt = MODE_NONE;
        end
      end
      ST_CONFIG: begin
        if (w_tmo) begin
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ACQUIRE;
        end else if (w_done) begin
          if (r_step == CFG_STEP_LAST) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_step_nxt = r_step + 3'd1;
          end
        end else if (!cfg_wr_o) begin
          w_start = 1'b1;
        end
      end
      ST_RUN: begin
        if ((det_valid_i && !w_match) || w_expire) begin
          w_state_nxt = ST_TEARDOWN;
          w_start     = 1'b1;
          w_req       = cfg_step(3'd0, r_ref_h, r_ref_v);
        end
      end
      ST_TEARDOWN: begin
        if (w_done) begin
          w_cnt_nxt   = '0;
          w_mode_nxt  = MODE_NONE;
          w_state_nxt = ST_ACQUIRE;
        end else if (w_tmo) begin
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ACQUIRE;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_ACQUIRE;
      r_cnt       <= '0;
      r_ref_h     <= '0;
      r_ref_v     <= '0;
      r_step      <= '0;
      r_mode      <= MODE_NONE;
      r_err       <= 1'b0;
      r_bridge_en <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ref_h     <= w_ref_h_nxt;
      r_ref_v     <= w_ref_v_nxt;
      r_step      <= w_step_nxt;
      r_mode      <= w_mode_nxt;
      r_err       <= w_err_nxt;
      r_bridge_en <= w_run_nxt;
      r_locked    <= w_run_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wdog <= '0;
    end else if (det_valid_i) begin
      r_wdog <= '0;
    end else if (r_wdog != WDOG_MAX) begin
      r_wdog <= r_wdog + WW'(1);
    end
  end

  cfg_writer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_cfg_writer (
    .i_clk    (sys_clk),
    .i_rst_n  (n_rst),
    .i_start  (w_start),
    .i_addr   (w_req.addr),
    .i_data   (w_req.data),
    .i_ack    (cfg_ack_i),
    .o_wr     (cfg_wr_o),
    .o_addr   (cfg_addr_o),
    .o_data   (cfg_data_o),
    .o_done   (w_done),
    .o_timeout(w_tmo)
  );

  assign bridge_en_o = r_bridge_en;
  assign locked_o    = r_locked;
  assign mode_o      = r_mode;
  assign err_o       = r_err;

endmodule

// File: tb/tb_format_ctrl.sv
// Directed bench for format_ctrl: acquisition, programming sequence, loss, ack timeout and async reset.
module tb_format_ctrl;

  localparam int LT = 400;
  localparam logic [4:0][19:0] EXP_720 = {20'h00000, {4'd1, 16'd1280}, {4'd2, 16'd720},
                                          {4'd3, 16'd2560}, {4'd0, 16'd1}};
  localparam logic [4:0][19:0] EXP_1080 = {20'h00000, {4'd1, 16'd1920}, {4'd2, 16'd1080},
                                           {4'd3, 16'd3840}, {4'd0, 16'd1}};

  logic        sys_clk = 1'b0;
  logic        n_rst;
  logic        det_valid_i;
  logic [11:0] det_h_active_i;
  logic [10:0] det_v_active_i;
  logic        cfg_wr_o;
  logic [3:0]  cfg_addr_o;
  logic [15:0] cfg_data_o;
  logic        cfg_ack_i;
  logic        bridge_en_o;
  logic        locked_o;
  logic [1:0]  mode_o;
  logic        err_o;
  logic        ack_en;

  int n_checks = 0;
  int n_errors = 0;
  logic [19:0] wr_q[$];

  format_ctrl #(
    .STABLE_FRAMES(3),
    .LOSS_TIMEOUT (LT),
    .ACK_TIMEOUT  (256)
  ) dut (
    .sys_clk       (sys_clk),
    .n_rst         (n_rst),
    .det_valid_i   (det_valid_i),
    .det_h_active_i(det_h_active_i),
    .det_v_active_i(det_v_active_i),
    .cfg_wr_o      (cfg_wr_o),
    .cfg_addr_o    (cfg_addr_o),
    .cfg_data_o    (cfg_data_o),
    .cfg_ack_i     (cfg_ack_i),
    .bridge_en_o   (bridge_en_o),
    .locked_o      (locked_o),
    .mode_o        (mode_o),
    .err_o         (err_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Zero-wait responder: acks in the same cycle the request is seen.
  assign cfg_ack_i = ack_en & cfg_wr_o;

  always @(negedge sys_clk) begin
    if (cfg_wr_o && cfg_ack_i) wr_q.push_back({cfg_addr_o, cfg_data_o});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse(input logic [11:0] h, input logic [10:0] v);
    det_valid_i    = 1'b1;
    det_h_active_i = h;
    det_v_active_i = v;
    @(posedge sys_clk);
    #1;
    det_valid_i = 1'b0;
  endtask

  task automatic acquire(input logic [11:0] h, input logic [10:0] v);
    pulse(h, v);
    tick();
    pulse(h, v);
    tick();
    pulse(h, v);
    @(negedge sys_clk);
  endtask

  // Called at the negedge of the first write cycle; returns the cycle index at which bridge_en is seen.
  task automatic measure_lock(output int n);
    n = 1;
    while (!bridge_en_o && n < 60) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic check_writes(input string tag, input logic [4:0][19:0] exp);
    check_eq({tag, "_nwr"}, wr_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("%s_wr%0d", tag, i), (i < wr_q.size()) ? wr_q[i] : 20'hFFFFF, exp[4-i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int len;
    n_rst = 1'b0;
    det_valid_i = 1'b0;
    det_h_active_i = '0;
    det_v_active_i = '0;
    ack_en = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_eq("rst_wr", cfg_wr_o, 0);
    check_eq("rst_bridge", bridge_en_o, 0);
    check_eq("rst_locked", locked_o, 0);
    check_eq("rst_mode", mode_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_addr_data", {cfg_addr_o, cfg_data_o}, 0);
    tick();
    n_rst = 1'b1;
    tick();

    // Stable 720p
    wr_q.delete();
    pulse(12'd1280, 11'd720);
    tick();
    pulse(12'd1280, 11'd720);
    tick();
    @(negedge sys_clk);
    check_eq("720_no_wr_before_3rd", cfg_wr_o, 0);
    pulse(12'd1280, 11'd720);
    @(negedge sys_clk);
    check_eq("720_wr_rise", cfg_wr_o, 1);
    measure_lock(len);
    check_eq("720_cfg_len", len, 10);
    check_eq("720_locked", locked_o, 1);
    check_eq("720_mode", mode_o, 1);
    check_writes("720", EXP_720);

    // Watchdog loss
    pulse(12'd1280, 11'd720);
    @(negedge sys_clk);
    check_eq("run_match_locked", locked_o, 1);
    wr_q.delete();
    repeat (LT - 1) tick();
    @(negedge sys_clk);
    check_eq("loss_not_early", bridge_en_o, 1);
    tick();
    @(negedge sys_clk);
    check_eq("loss_bridge_fall", bridge_en_o, 0);
    check_eq("loss_locked_fall", locked_o, 0);
    check_eq("loss_td_wr", cfg_wr_o, 1);
    check_eq("loss_td_addr_data", {cfg_addr_o, cfg_data_o}, 0);
    tick();
    @(negedge sys_clk);
    check_eq("loss_mode_none", mode_o, 0);
    check_eq("loss_td_nwr", wr_q.size(), 1);

    // Pulse coinciding with watchdog expiry keeps lock
    acquire(12'd1280, 11'd720);
    measure_lock(len);
    check_eq("relock_bridge", bridge_en_o, 1);
    pulse(12'd1280, 11'd720);
    repeat (LT - 1) tick();
    pulse(12'd1280, 11'd720);
    @(negedge sys_clk);
    check_eq("tie_bridge", bridge_en_o, 1);
    check_eq("tie_no_wr", cfg_wr_o, 0);
    repeat (5) tick();
    @(negedge sys_clk);
    check_eq("tie_still_locked", locked_o, 1);

    // Mismatch in RUN
    pulse(12'd1920, 11'd1080);
    @(negedge sys_clk);
    check_eq("mism_bridge_fall", bridge_en_o, 0);
    check_eq("mism_td_wr", cfg_wr_o, 1);
    repeat (2) tick();

    // Unstable then stable 1080p
    wr_q.delete();
    pulse(12'd1280, 11'd720);
    tick();
    pulse(12'd1920, 11'd1080);
    tick();
    pulse(12'd1920, 11'd1080);
    @(negedge sys_clk);
    check_eq("unst_no_wr_3rd", cfg_wr_o, 0);
    pulse(12'd1920, 11'd1080);
    @(negedge sys_clk);
    check_eq("unst_wr_4th", cfg_wr_o, 1);
    measure_lock(len);
    check_eq("1080_cfg_len", len, 10);
    check_eq("1080_mode", mode_o, 2);
    check_writes("1080", EXP_1080);

    // Unsupported size
    pulse(12'd720, 11'd576);
    repeat (2) tick();
    wr_q.delete();
    pulse(12'd720, 11'd576);
    tick();
    pulse(12'd720, 11'd576);
    @(negedge sys_clk);
    check_eq("unsup_mode_before", mode_o, 0);
    pulse(12'd720, 11'd576);
    repeat (5) tick();
    @(negedge sys_clk);
    check_eq("unsup_mode", mode_o, 3);
    check_eq("unsup_locked", locked_o, 0);
    check_eq("unsup_no_wr", cfg_wr_o, 0);
    check_eq("unsup_nwr", wr_q.size(), 0);

    // Ack timeout, then successful re-acquire
    ack_en = 1'b0;
    acquire(12'd1280, 11'd720);
    len = 0;
    while (cfg_wr_o && len < 400) begin
      len++;
      @(negedge sys_clk);
    end
    check_eq("tmo_wr_len", len, 256);
    check_eq("tmo_err", err_o, 1);
    check_eq("tmo_locked", locked_o, 0);
    repeat (3) tick();
    @(negedge sys_clk);
    check_eq("tmo_no_retry", cfg_wr_o, 0);
    ack_en = 1'b1;
    wr_q.delete();
    acquire(12'd1280, 11'd720);
    check_eq("tmo_reacq_wr", cfg_wr_o, 1);
    measure_lock(len);
    check_eq("tmo_reacq_lock", bridge_en_o, 1);
    check_writes("tmo_reacq", EXP_720);
    check_eq("tmo_err_sticky", err_o, 1);

    // Async reset during the third config write
    pulse(12'd1920, 11'd1080);
    repeat (2) tick();
    acquire(12'd1920, 11'd1080);
    @(negedge sys_clk);
    @(negedge sys_clk);
    @(negedge sys_clk);
    ack_en = 1'b0;
    @(negedge sys_clk);
    check_eq("rstw_pre_wr", cfg_wr_o, 1);
    check_eq("rstw_pre_addr_data", {cfg_addr_o, cfg_data_o}, {4'd2, 16'd1080});
    #1;
    n_rst = 1'b0;
    #1;
    check_eq("rstw_wr", cfg_wr_o, 0);
    check_eq("rstw_bridge", bridge_en_o, 0);
    check_eq("rstw_mode", mode_o, 0);
    check_eq("rstw_err", err_o, 0);
    tick();
    n_rst = 1'b1;
    ack_en = 1'b1;
    wr_q.delete();
    tick();
    acquire(12'd1920, 11'd1080);
    measure_lock(len);
    check_eq("rstw_cfg_len", len, 10);
    check_eq("rstw_mode_after", mode_o, 2);
    check_writes("rstw", EXP_1080);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/format_ctrl.md
# format_ctrl

Sequencing controller between the SDI video format detector and the MIPI CSI-2 transmitter configuration port. It qualifies the detector's per-frame measurements until they are stable and supported, then programs the transmitter over a register-write handshake and enables the bridge. It tears the configuration down on loss or format change and re-acquires. Runs entirely in the `sys_clk` domain; the detector results arrive already synchronised.

## Interface

- `STABLE_FRAMES`, 3: consecutive identical measurements required before configuring (≥2).
- `LOSS_TIMEOUT`, 2_000_000: `sys_clk` cycles without `det_valid_i` that declare signal loss.
- `ACK_TIMEOUT`, 256: cycles to wait for `cfg_ack_i` before aborting a write.

Ports:

- `sys_clk` in 1: system clock. One clock; reset is asynchronous and active-low.
- `n_rst` in 1: asynchronous active-low reset.
- `det_valid_i` in 1: one-cycle pulse per measured frame.
- `det_h_active_i` in 12: measured active pixels per line.
- `det_v_active_i` in 11: measured active lines per frame.
- `cfg_wr_o` out 1: write request, held until acknowledged.
- `cfg_addr_o` out 4: register address.
- `cfg_data_o` out 16: register data.
- `cfg_ack_i` in 1: write accepted (single-cycle).
- `bridge_en_o` out 1: bridge datapath enable.
- `locked_o` out 1: valid configuration active.
- `mode_o` out 2: 0 none, 1 = 1280x720, 2 = 1920x1080, 3 unsupported.
- `err_o` out 1: sticky ack-timeout flag; cleared only by reset.

## Operation

- Reset values: all outputs are 0; state is ACQUIRE; the match count is 0.
- **ACQUIRE**
  - On `det_valid_i`, compare the measurement with the stored reference.
  - If it matches, increment the match count, saturating at `STABLE_FRAMES`.
  - Otherwise load the reference and set the count to 1.
  - When the count reaches `STABLE_FRAMES`:
    - Supported size: go to CONFIG and latch `mode_o`.
    - Otherwise: set `mode_o`=3 and remain in ACQUIRE.
- **CONFIG**: issue the writes in order.
  - addr 0 data 0 (CTRL disable).
  - addr 1 data H_ACTIVE.
  - addr 2 data V_ACTIVE.
  - addr 3 data WC = H_ACTIVE×2, computed in 16 bits with zero-extension and no overflow for 12-bit input.
  - addr 0 data 1.
  - After the last ack: go to RUN.
- **RUN**: `bridge_en_o`=1 and `locked_o`=1.
  - Each `det_valid_i` must match the reference.
  - A mismatch or the watchdog reaching `LOSS_TIMEOUT` leads to TEARDOWN.
- **TEARDOWN**:
  - Clear `bridge_en_o` and `locked_o` on entry.
  - Write addr 0 data 0.
  - After the ack: go to ACQUIRE with the count at 0 and `mode_o`=0.
- Watchdog:
  - Cleared on every `det_valid_i`.
  - Also active in ACQUIRE, where timeout resets the count to 0 and `mode_o` to 0.
  - Saturates; it does not wrap.
- Ack timeout:
  - In CONFIG or TEARDOWN, if `cfg_ack_i` has not arrived within `ACK_TIMEOUT` cycles of the request, drop `cfg_wr_o`.
  - Set `err_o`, then go to ACQUIRE with the count at 0.
- `det_valid_i` during CONFIG or TEARDOWN:
  - Only clears the watchdog.
  - A mismatch during CONFIG is checked at RUN entry by the next measurement.

## Timing

- `cfg_wr_o` rises in the cycle after the `det_valid_i` that completes stability.
- Handshake:
  - `cfg_addr_o`/`cfg_data_o` are stable while `cfg_wr_o`=1.
  - Writes are accepted on a cycle where `cfg_wr_o` and `cfg_ack_i` are both 1.
  - `cfg_wr_o` drops for exactly one cycle before the next write.
  - `cfg_ack_i` while `cfg_wr_o`=0 is ignored.
- With zero-wait acks, the full CONFIG sequence takes 10 cycles.
- RUN outputs rise in the cycle after the final ack.
- Loss:
  - `bridge_en_o` falls in the cycle after the mismatching `det_valid_i`, or after the watchdog hits `LOSS_TIMEOUT`.
  - The TEARDOWN write is issued that same cycle.
- A watchdog expiry coinciding with `det_valid_i` is resolved in favour of `det_valid_i` (no loss).
- Asserting `n_rst` mid-write drops `cfg_wr_o` immediately.
- All outputs are registered.

## Structure

- Shared package `sdi_bridge_pkg`:
  - State enum (ACQUIRE, CONFIG, RUN, TEARDOWN).
  - Register addresses.
  - Mode codes.
  - Supported resolution constants (1280/720, 1920/1080).
- Sub-module `cfg_writer`:
  - Single-write handshake engine with ack timeout.
  - Inputs: start, addr, data. Outputs: done, timeout.
  - Used by both CONFIG and TEARDOWN.
- Top level: stability counter, watchdog and sequencing FSM.

## Test plan

- **Stable 720p:** 3 pulses of 1280/720 with immediate ack → 5 writes (0/0, 1/1280, 2/720, 3/2560, 0/1); `bridge_en_o`=1, `mode_o`=1.
- **Unstable then stable:** 1280/720, 1920/1080, 1920/1080, 1920/1080 → config only after the 4th pulse; WC=3840, `mode_o`=2.
- **Unsupported:** 3× 720/576 → no writes; `mode_o`=3, `locked_o`=0.
- **Loss:**
  - Locked 720p, then no pulses for `LOSS_TIMEOUT` cycles → `bridge_en_o` falls and a 0/0 write is issued; back to ACQUIRE.
  - A pulse in the same cycle as expiry → stays locked.
- **Ack timeout:** `cfg_ack_i` held 0 → `cfg_wr_o` drops after 256 cycles and `err_o`=1; re-acquire succeeds after 3 more pulses.
- **Async reset during the 3rd config write:** all outputs are 0 immediately; full reconfiguration follows 3 fresh pulses.
